// File: rtl/photon_window_counter_pkg.sv
// Shared types and constants for the photon window counter: FSM states,
// the debug view of the counting core, and the saturation helper.
package pwc_pkg;

    localparam int DEFAULT_CNT_W       = 32;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } pwc_state_e;

    typedef struct packed {
        pwc_state_e state;
        logic       armed;
        logic       load_pending;
        logic       gate_s;
        logic       gate_d;
        logic       gate_rise;
        logic       gate_fall;
        logic       ph_s;
        logic       ph_d;
        logic       ph_rise;
        logic       ph_fall;
    } pwc_dbg_t;

    // All-ones value of a width-bit counter, computed at elaboration time.
    function automatic logic [63:0] sat_max(input int unsigned width);
        if (width >= 64) begin
            return {64{1'b1}};
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/photon_window_counter_if.sv
// Result readback channel of the photon window counter.
// Handshake: the producer raises countValid with count/cycles/overflow held
// stable; a rising CLK edge with countValid & countReady consumes the result.
// The producer may replace a pending result, which keeps countValid high.
interface photon_window_counter_if #(
    parameter int CNT_W = pwc_pkg::DEFAULT_CNT_W
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cycles;
    logic             countValid;
    logic             countReady;
    logic             overflow;

    modport master (
        output count,
        output cycles,
        output countValid,
        output overflow,
        input  countReady
    );

    modport slave (
        input  count,
        input  cycles,
        input  countValid,
        input  overflow,
        output countReady
    );
endinterface

// File: rtl/photon_window_counter_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, plus a delayed copy
// and single-cycle rise/fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic dly,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
            dly_q   <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
            dly_q   <= chain_q[STAGES-1];
        end
    end

    assign sync = chain_q[STAGES-1];
    assign dly  = dly_q;
    assign rise = chain_q[STAGES-1] & ~dly_q;
    assign fall = ~chain_q[STAGES-1] & dly_q;

endmodule

// File: rtl/photon_window_counter.sv
// Counts synchronized photon edges while the command gate is high, then
// publishes the photon count and window length on a valid/ready channel.
module photon_window_counter
    import pwc_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    COUNT_SIG,
    input  logic                    PHOTON,
    photon_window_counter_if.master res,
    output logic                    dropped,
    output logic                    busy,
    output pwc_dbg_t                dbg
);

    localparam logic [63:0]      SAT64 = sat_max(CNT_W);
    localparam logic [CNT_W-1:0] SAT   = SAT64[CNT_W-1:0];

    logic gate_s, gate_d, gate_rise, gate_fall;
    logic ph_s, ph_d, ph_rise, ph_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_gate_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (COUNT_SIG),
        .sync (gate_s),
        .dly  (gate_d),
        .rise (gate_rise),
        .fall (gate_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_photon_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (PHOTON),
        .sync (ph_s),
        .dly  (ph_d),
        .rise (ph_rise),
        .fall (ph_fall)
    );

    pwc_state_e       state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_sat;
    logic [CNT_W-1:0] cyc_q, cyc_d, cyc_sat;
    logic             ovf_q, ovf_d;
    logic             load_q, load_d;
    logic [SYNC_STAGES:0] prime_q;
    logic             armed_q;

    logic [CNT_W-1:0] count_q, cycles_q;
    logic             overflow_q, valid_q, dropped_q;

    assign acc_sat = (acc_q == SAT) ? acc_q : acc_q + CNT_W'(1);
    assign cyc_sat = (cyc_q == SAT) ? cyc_q : cyc_q + CNT_W'(1);

    // The synchronizer holds reset zeros for a few cycles after RST; a window
    // may only open once the real gate level has been observed low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prime_q <= '0;
            armed_q <= 1'b0;
        end else begin
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            if (prime_q[SYNC_STAGES] && !gate_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cyc_d   = cyc_q;
        ovf_d   = ovf_q;
        load_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gate_rise && armed_q) begin
                    state_d = COUNTING;
                    acc_d   = ph_rise ? CNT_W'(1) : '0;
                    cyc_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                end
            end
            COUNTING: begin
                if (gate_fall) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                end else if (gate_s) begin
                    cyc_d = cyc_sat;
                    if (ph_rise) begin
                        acc_d = acc_sat;
                    end
                    ovf_d = ovf_q | (cyc_sat == SAT) | (ph_rise && (acc_sat == SAT));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cyc_q   <= '0;
            ovf_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cyc_q   <= cyc_d;
            ovf_q   <= ovf_d;
            load_q  <= load_d;
        end
    end

    // acc/cyc stay frozen in IDLE, so the load one cycle after the gate fall
    // still sees the closed window even if a new one opens that same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q    <= '0;
            cycles_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else if (load_q) begin
            count_q    <= acc_q;
            cycles_q   <= cyc_q;
            overflow_q <= ovf_q;
            valid_q    <= 1'b1;
            if (valid_q && !res.countReady) begin
                dropped_q <= 1'b1;
            end
        end else if (valid_q && res.countReady) begin
            valid_q <= 1'b0;
        end
    end

    assign res.count      = count_q;
    assign res.cycles     = cycles_q;
    assign res.overflow   = overflow_q;
    assign res.countValid = valid_q;
    assign dropped        = dropped_q;
    assign busy           = (state_q == COUNTING);

    assign dbg = '{
        state:        state_q,
        armed:        armed_q,
        load_pending: load_q,
        gate_s:       gate_s,
        gate_d:       gate_d,
        gate_rise:    gate_rise,
        gate_fall:    gate_fall,
        ph_s:         ph_s,
        ph_d:         ph_d,
        ph_rise:      ph_rise,
        ph_fall:      ph_fall
    };

endmodule

// File: doc/photon_window_counter.md
# photon_window_counter

Downstream of the command decoder: counts photon-detector pulses while the decoder's count-enable gate (COUNT_SIG) is high. On the gate's falling edge it freezes the photon count and window length into a result register and offers them to the readback path via a valid/ready handshake. It is the measurement core of the single-pixel acquisition: one gate window equals one pattern exposure.

## Interface
- CNT_W, 32, width of the photon count and the window-cycle count.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (minimum 2).
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- COUNT_SIG  input  1  gate from the command decoder; asynchronous to CLK because it is produced on the rxValid edge, so it is synchronized internally.
- PHOTON  input  1  detector pulse train, asynchronous; one rising edge is one photon.
- count  output  CNT_W  photon count of the last completed window.
- cycles  output  CNT_W  CLK cycles the synchronized gate was high in that window.
- countValid  output  1  the result register holds an unconsumed result.
- countReady  input  1  consumer accepts the result.
- overflow  output  1  the photon or cycle counter saturated in the reported window.
- dropped  output  1  sticky: a result was overwritten before it was consumed.
- busy  output  1  a window is open (state COUNTING).

## Operation
- Each of PHOTON and COUNT_SIG passes through its own SYNC_STAGES synchronizer, producing ph_s and gate_s. A flop on each gives ph_d and gate_d.
- A photon edge is ph_s & ~ph_d. A gate rise is gate_s & ~gate_d. A gate fall is ~gate_s & gate_d.
- FSM states:
  - IDLE: on gate rise, go to COUNTING. Load acc to 1 if a photon edge occurs in the same cycle, otherwise 0. Load cyc to 1 and clear ovf_acc.
  - COUNTING: each cycle with gate_s high, cyc += 1, and acc += 1 on a photon edge. On gate fall, go to IDLE. That cycle neither increments nor counts a photon edge.
- Counters saturate at 2^CNT_W−1 and never wrap. Reaching the saturated value sets ovf_acc.
- On the gate-fall cycle, the result register loads count=acc, cycles=cyc and overflow=ovf_acc. countValid is set on the next edge.
- If countValid is already high when a new result loads, the old result is overwritten, dropped is set and countValid stays high.
- Handshake:
  - countValid & countReady on a rising edge clears countValid.
  - count, cycles and overflow stay stable while countValid is high and no new load occurs.
  - If a load and an accept happen in the same cycle, the load wins: the new result is presented, countValid stays 1 and dropped is not set.
- dropped clears only on RST.
- A new window may open while a result is pending. acc and cyc are independent of the result register.

## Timing
- Reset values: count=0, cycles=0, countValid=0, overflow=0, dropped=0, busy=0. FSM is IDLE, and the synchronizers and edge flops are 0.
- COUNT_SIG change to busy change: SYNC_STAGES+1 cycles.
- PHOTON rising edge to acc increment: SYNC_STAGES+1 cycles.
- COUNT_SIG fall to countValid=1: SYNC_STAGES+2 cycles.
- PHOTON high and low times must each be at least 1.5 CLK periods for guaranteed counting, giving a maximum rate of CLK/3. Narrower pulses may be missed but never double-counted.
- RST mid-window: the window is discarded and no result is produced. After release, a gate already high is not treated as a rise until it has been seen low.

## Structure
- Shared package `pwc_pkg`:
  - FSM state enum (IDLE, COUNTING).
  - Default CNT_W and SYNC_STAGES.
  - Saturation-max constant function.
- Sub-module `sync_edge` (parameter STAGES), instantiated twice. It provides the synchronizer, delayed copy, and rise/fall pulses.

## Test plan
- Gate high for 1000 CLK with 37 well-spaced PHOTON pulses, countReady=1 → one countValid pulse, count=37, cycles=1000, overflow=0.
- Result pending with countReady=0 → a second window with 5 photons → count=5, dropped=1, countValid held. Then countReady=1 for one cycle → countValid=0.
- CNT_W=4, gate window with 20 photons → count=15, overflow=1. Then a clean window of 3 photons → count=3, overflow=0.
- PHOTON edge aligned with the synchronized gate-rise cycle is counted (count=1). An edge on the gate-fall cycle is not counted.
- RST asserted mid-window with COUNT_SIG held high → all outputs reset. After release no result is produced until COUNT_SIG goes low then high again.
- PHOTON pulses 1 CLK wide at CLK/2 → count ≤ number of pulses and never greater. Pulses 2 CLK high / 2 CLK low → exact count.
